branch_resolution_unit: RTL and testbench

//   Sits downstream of the branch prediction unit. Carries each fetched instruction's

---
 rtl/branch_resolution_unit.sv | 128 ++++++++++++
 tb/tb_branch_resolution_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: carries BPU prediction metadata through ID and EX, checks it
// against the ALU outcome, drives flush/redirect and the registered BHT training update.
module branch_resolution_unit #(
   parameter int PC_WIDTH  = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_valid,
   input  logic [PC_WIDTH-1:0]  if_pc,
   input  logic                 if_prediction,
   input  logic [PC_WIDTH-1:0]  if_pred_target,
   input  logic                 stall,
   input  logic                 ex_is_branch,
   input  logic                 ex_taken,
   input  logic [PC_WIDTH-1:0]  ex_target,
   output logic                 flush,
   output logic [PC_WIDTH-1:0]  redirect_pc,
   output logic                 bpu_branch,
   output logic                 bpu_branch_taken,
   output logic [PC_WIDTH-1:0]  bpu_pc,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   typedef struct packed {
      logic                valid;
      logic [PC_WIDTH-1:0] pc;
      logic                pred;
      logic [PC_WIDTH-1:0] pred_target;
   } stage_t;

   localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   stage_t                id_q, id_d;
   stage_t                ex_q, ex_d;
   logic                  bpu_branch_q, bpu_branch_d;
   logic                  bpu_taken_q, bpu_taken_d;
   logic [PC_WIDTH-1:0]   bpu_pc_q, bpu_pc_d;
   logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
   logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

   logic act_taken;
   logic mispredict;
   logic resolve_en;

   // Resolution is purely combinational from the EX stage; an invalid EX reports nothing.
   always_comb begin
      act_taken   = ex_is_branch & ex_taken;
      mispredict  = (ex_q.pred != act_taken) |
                    (ex_q.pred & act_taken & (ex_q.pred_target != ex_target));
      resolve_en  = ex_q.valid & ex_is_branch;
      flush       = ex_q.valid & mispredict;
      redirect_pc = '0;
      if (ex_q.valid) begin
         redirect_pc = act_taken ? ex_target : ex_q.pc + PC_ONE;
      end
   end

   // NOTE: every variable gets a default at the top of the block so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      id_d          = id_q;
      ex_d          = ex_q;
      bpu_branch_d  = resolve_en;
      bpu_taken_d   = bpu_taken_q;
      bpu_pc_d      = bpu_pc_q;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;

      if (flush) begin
         id_d.valid = 1'b0;
         ex_d.valid = 1'b0;
      end else if (stall) begin
         ex_d.valid = 1'b0;
      end else begin
         id_d.valid       = if_valid;
         id_d.pc          = if_pc;
         id_d.pred        = if_prediction;
         id_d.pred_target = if_pred_target;
         ex_d             = id_q;
      end

      // Only real branches train the BHT; an aliased non-branch flush leaves it alone.
      if (resolve_en) begin
         bpu_taken_d = ex_taken;
         bpu_pc_d    = ex_q.pc;
      end

      if (resolve_en && (branch_cnt_q != CNT_MAX)) begin
         branch_cnt_d = branch_cnt_q + CNT_ONE;
      end
      if (flush && (mispred_cnt_q != CNT_MAX)) begin
         mispred_cnt_d = mispred_cnt_q + CNT_ONE;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of the order of statements in the block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_q          <= '0;
         ex_q          <= '0;
         bpu_branch_q  <= 1'b0;
         bpu_taken_q   <= 1'b0;
         bpu_pc_q      <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         id_q          <= id_d;
         ex_q          <= ex_d;
         bpu_branch_q  <= bpu_branch_d;
         bpu_taken_q   <= bpu_taken_d;
         bpu_pc_q      <= bpu_pc_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bpu_branch       = bpu_branch_q;
   assign bpu_branch_taken = bpu_taken_q;
   assign bpu_pc           = bpu_pc_q;
   assign branch_count     = branch_cnt_q;
   assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: stimulus pushes expected flush/redirect
// and BHT-update events, a negedge monitor pops and compares them as the DUT emits them.
module tb_branch_resolution_unit;

   localparam int PW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_valid = 1'b0;
   logic [PW-1:0] if_pc = '0;
   logic          if_prediction = 1'b0;
   logic [PW-1:0] if_pred_target = '0;
   logic          stall = 1'b0;
   logic          ex_is_branch = 1'b0;
   logic          ex_taken = 1'b0;
   logic [PW-1:0] ex_target = '0;
   logic          flush;
   logic [PW-1:0] redirect_pc;
   logic          bpu_branch;
   logic          bpu_branch_taken;
   logic [PW-1:0] bpu_pc;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;

   int total = 0;
   int bad   = 0;

   logic [PW-1:0] flush_q[$];
   logic [PW:0]   bpu_q[$];

   branch_resolution_unit #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
      .clk              (clk),
      .reset            (reset),
      .if_valid         (if_valid),
      .if_pc            (if_pc),
      .if_prediction    (if_prediction),
      .if_pred_target   (if_pred_target),
      .stall            (stall),
      .ex_is_branch     (ex_is_branch),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .bpu_branch       (bpu_branch),
      .bpu_branch_taken (bpu_branch_taken),
      .bpu_pc           (bpu_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: any flush or BHT strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (flush) begin
            if (flush_q.size() == 0) check("unexpected_flush", {24'h0, redirect_pc}, 32'hFFFF_FFFF);
            else check("redirect_pc", {24'h0, redirect_pc}, {24'h0, flush_q.pop_front()});
         end
         if (bpu_branch) begin
            if (bpu_q.size() == 0) check("unexpected_bpu", {23'h0, bpu_branch_taken, bpu_pc}, 32'hFFFF_FFFF);
            else check("bpu_update", {23'h0, bpu_branch_taken, bpu_pc}, {23'h0, bpu_q.pop_front()});
         end
      end
   end

   // Applies inputs 1 time unit after the next rising edge; they hold for that cycle.
   task automatic step(input bit ifv, input logic [PW-1:0] pc, input bit pred,
                       input logic [PW-1:0] ptgt, input bit stl, input bit exb,
                       input bit ext, input logic [PW-1:0] etgt);
      @(posedge clk);
      #1;
      if_valid       = ifv;
      if_pc          = pc;
      if_prediction  = pred;
      if_pred_target = ptgt;
      stall          = stl;
      ex_is_branch   = exb;
      ex_taken       = ext;
      ex_target      = etgt;
   endtask

   // Idle cycle: EX is expected empty, so a taken branch on the ALU side must be ignored.
   task automatic poison(input bit stl);
      step(1'b0, 8'h00, 1'b0, 8'h00, stl, 1'b1, 1'b1, 8'h77);
   endtask

   task automatic expect_events(input bit exp_flush, input logic [PW-1:0] exp_redir,
                                input bit isbr, input bit taken, input logic [PW-1:0] pc);
      if (exp_flush) flush_q.push_back(exp_redir);
      if (isbr) bpu_q.push_back({taken, pc});
   endtask

   task automatic issue(input logic [PW-1:0] pc, input bit pred, input logic [PW-1:0] ptgt,
                        input bit isbr, input bit taken, input logic [PW-1:0] tgt,
                        input bit exp_flush, input logic [PW-1:0] exp_redir);
      step(1'b1, pc, pred, ptgt, 1'b0, 1'b1, 1'b1, 8'h77);
      poison(1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, isbr, taken, tgt);
      expect_events(exp_flush, exp_redir, isbr, taken, pc);
      poison(1'b0);
   endtask

   initial begin
      #1;
      check("rst_flush", {31'h0, flush}, 32'h0);
      check("rst_redirect", {24'h0, redirect_pc}, 32'h0);
      check("rst_bpu", {22'h0, bpu_branch, bpu_branch_taken, bpu_pc}, 32'h0);
      check("rst_counts", {24'h0, branch_count, mispredict_count}, 32'h0);
      #11;
      reset = 1'b0;

      // T1 correct not-taken
      issue(8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 8'h00);
      check("t1_counts", {24'h0, branch_count, mispredict_count}, {24'h0, 4'd1, 4'd0});
      // T2 taken mispredict
      issue(8'h20, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b1, 8'h40);
      check("t2_counts", {24'h0, branch_count, mispredict_count}, {24'h0, 4'd2, 4'd1});
      // T3 wrong target
      issue(8'h30, 1'b1, 8'h50, 1'b1, 1'b1, 8'h60, 1'b1, 8'h60);
      // correct taken, then predicted-taken but not taken
      issue(8'h40, 1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00);
      issue(8'h50, 1'b1, 8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 8'h51);
      check("mix_counts", {24'h0, branch_count, mispredict_count}, {24'h0, 4'd5, 4'd3});
      // T4 aliased non-branch with PC wrap, then a harmless non-branch
      issue(8'hFF, 1'b1, 8'h12, 1'b0, 1'b1, 8'h33, 1'b1, 8'h00);
      issue(8'h60, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00);
      check("t4_counts", {24'h0, branch_count, mispredict_count}, {24'h0, 4'd5, 4'd4});

      // T5a flush beats stall: A mispredicts in EX while B sits in ID and stall is high
      step(1'b1, 8'h70, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77);
      step(1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h90);
      expect_events(1'b1, 8'h90, 1'b1, 1'b1, 8'h70);
      poison(1'b0);
      poison(1'b0);
      poison(1'b0);
      check("t5a_counts", {24'h0, branch_count, mispredict_count}, {24'h0, 4'd6, 4'd5});

      // T5b stall alone: C held in ID for two cycles while D is offered on IF
      step(1'b1, 8'hA0, 1'b1, 8'hA8, 1'b0, 1'b1, 1'b1, 8'h77);
      step(1'b1, 8'hB0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77);
      step(1'b1, 8'hB0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77);
      poison(1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA8);
      expect_events(1'b0, 8'h00, 1'b1, 1'b1, 8'hA0);
      poison(1'b0);
      poison(1'b0);
      check("t5b_counts", {24'h0, branch_count, mispredict_count}, {24'h0, 4'd7, 4'd5});

      // T6 reset asserted in the middle of a flush cycle
      step(1'b1, 8'h05, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h77);
      poison(1'b0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33);
      expect_events(1'b1, 8'h06, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t6_flush", {31'h0, flush}, 32'h0);
      check("t6_redirect", {24'h0, redirect_pc}, 32'h0);
      check("t6_bpu", {22'h0, bpu_branch, bpu_branch_taken, bpu_pc}, 32'h0);
      check("t6_counts", {24'h0, branch_count, mispredict_count}, 32'h0);
      poison(1'b0);
      @(negedge clk);
      check("t6_held_flush", {31'h0, flush}, 32'h0);
      check("t6_held_redirect", {24'h0, redirect_pc}, 32'h0);
      #2;
      reset = 1'b0;

      // Saturation: 20 mispredicting branches against 4-bit counters
      for (int i = 0; i < 20; i++) begin
         issue(8'(8'hC0 + i), 1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h10 + i));
         if (i == 14) check("sat_at_15", {24'h0, branch_count, mispredict_count}, {24'h0, 4'd15, 4'd15});
      end
      check("sat_counts", {24'h0, branch_count, mispredict_count}, {24'h0, 4'd15, 4'd15});

      poison(1'b0);
      poison(1'b0);
      @(negedge clk);
      check("flush_queue_drained", flush_q.size(), 32'd0);
      check("bpu_queue_drained", bpu_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
